seq_calculator: RTL and testbench

- Parametrised, clocked successor of the team's 4-bit combinational calculator: same four operators (add, sub, mul, div), generalised to WIDTH bits.
- Multiply (shift-add) and divide (restoring) are iterative, one bit per cycle, instead of single-cycle.
- Adds a start/busy/done handshake, full-width product, remainder and status flags.
- Sits between the operand/operator input stage and the display/result register stage.

---
 rtl/seq_calculator.sv | 138 +++++++++++++
 tb/tb_seq_calculator.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seq_calculator.sv
// Sequential calculator: add/sub in one step, shift-add multiply and
// restoring divide one bit per cycle, with start/busy/done handshake.
module seq_calculator #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic [1:0]       i_selOperator,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_result_hi,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_divZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b;
  logic [1:0]       r_op;
  logic [CW-1:0]    r_cnt;
  // Multiply accumulator: upper WIDTH+1 bits collect partial sums, lower
  // WIDTH bits start as the multiplier and shift out LSB-first.
  logic [2*WIDTH:0] r_acc;
  // Divide: partial remainder (one guard bit) and dividend/quotient shifter.
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;

  logic [WIDTH:0]   w_add, w_sub, w_mul_hi, w_rem_sh, w_diff;

  // Datapath for one add/sub result and one mul/div iteration.
  always_comb begin
    w_add    = {1'b0, r_a} + {1'b0, r_b};
    w_sub    = {1'b0, r_a} - {1'b0, r_b};
    w_mul_hi = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_a} : '0);
    w_rem_sh = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_b};
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_result    <= '0;
      o_result_hi <= '0;
      o_carry     <= 1'b0;
      o_overflow  <= 1'b0;
      o_divZero   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (i_start && !o_done) begin
            r_a    <= i_A;
            r_b    <= i_B;
            r_op   <= i_selOperator;
            r_cnt  <= '0;
            r_acc  <= {{(WIDTH+1){1'b0}}, i_B};
            r_rem  <= '0;
            r_q    <= i_A;
            o_busy <= 1'b1;
            if (!i_selOperator[1] || (i_selOperator[0] && i_B == '0))
              r_state <= S_DONE;
            else
              r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (!r_op[0]) begin
            r_acc <= {1'b0, w_mul_hi, r_acc[WIDTH-1:1]};
          end else if (!w_diff[WIDTH]) begin
            r_rem <= w_diff;
            r_q   <= {r_q[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_rem_sh;
            r_q   <= {r_q[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) r_state <= S_DONE;
        end
        S_DONE: begin
          o_busy     <= 1'b0;
          o_done     <= 1'b1;
          o_carry    <= 1'b0;
          o_overflow <= 1'b0;
          o_divZero  <= 1'b0;
          r_state    <= S_IDLE;
          case (r_op)
            2'b00: begin
              o_result    <= w_add[WIDTH-1:0];
              o_result_hi <= '0;
              o_carry     <= w_add[WIDTH];
            end
            2'b01: begin
              o_result    <= w_sub[WIDTH-1:0];
              o_result_hi <= '0;
              o_carry     <= w_sub[WIDTH];
            end
            2'b10: begin
              o_result    <= r_acc[WIDTH-1:0];
              o_result_hi <= r_acc[2*WIDTH-1:WIDTH];
              o_overflow  <= |r_acc[2*WIDTH-1:WIDTH];
            end
            default: begin
              if (r_b == '0) begin
                o_result    <= '0;
                o_result_hi <= '0;
                o_divZero   <= 1'b1;
              end else begin
                o_result    <= r_q;
                o_result_hi <= r_rem[WIDTH-1:0];
              end
            end
          endcase
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_calculator.sv
// Self-checking bench for seq_calculator (WIDTH=8): directed table,
// randomized ops against an arithmetic model, and multi-cycle corner cases.
module tb_seq_calculator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic [1:0] op;
  logic       busy, done, carry, ovf, dz;
  logic [7:0] res, res_hi;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] prev_res = '0;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a, b, res, hi;
    logic       c, ov, dz;
    int         lat;
  } vec_t;

  vec_t tbl[6];

  seq_calculator #(.WIDTH(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_A(a), .i_B(b),
    .i_selOperator(op), .o_busy(busy), .o_done(done), .o_result(res),
    .o_result_hi(res_hi), .o_carry(carry), .o_overflow(ovf), .o_divZero(dz)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Reference: plain integer arithmetic on the operator definition.
  function automatic vec_t model(logic [1:0] o, logic [7:0] x, logic [7:0] y);
    vec_t v;
    int p;
    v = '{op: o, a: x, b: y, res: 8'd0, hi: 8'd0, c: 1'b0, ov: 1'b0, dz: 1'b0, lat: 1};
    case (o)
      2'd0: begin p = int'(x) + int'(y); v.res = 8'(p % 256); v.c = (p > 255); end
      2'd1: begin p = int'(x) - int'(y) + 256; v.res = 8'(p % 256); v.c = (x < y); end
      2'd2: begin p = int'(x) * int'(y); v.res = 8'(p % 256); v.hi = 8'(p / 256);
                  v.ov = (p > 255); v.lat = 9; end
      default: begin
        if (y == 0) v.dz = 1'b1;
        else begin v.res = 8'(int'(x) / int'(y)); v.hi = 8'(int'(x) % int'(y)); v.lat = 9; end
      end
    endcase
    return v;
  endfunction

  // Launch one op, follow it to o_done (bounded), check latency and outputs.
  task automatic run_op(input vec_t v, input string tag);
    int cyc;
    @(negedge clk);
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
    cyc = 0;
    while (!done && cyc < 40) begin
      if (busy !== 1'b1) chk({tag, " busy"}, int'(busy), 1);
      if (res !== prev_res) chk({tag, " hold"}, int'(res), int'(prev_res));
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, cyc, v.lat);
    chk({tag, " busy@done"}, int'(busy), 0);
    chk({tag, " result"}, int'(res), int'(v.res));
    chk({tag, " hi"}, int'(res_hi), int'(v.hi));
    chk({tag, " carry"}, int'(carry), int'(v.c));
    chk({tag, " ovf"}, int'(ovf), int'(v.ov));
    chk({tag, " divzero"}, int'(dz), int'(v.dz));
    prev_res = v.res;
    @(posedge clk); #1;
    if (done !== 1'b0) chk({tag, " done pulse"}, int'(done), 0);
    if (res !== v.res) chk({tag, " post hold"}, int'(res), int'(v.res));
  endtask

  initial begin
    int ndone, dk;
    logic [7:0] dres;

    tbl[0] = '{2'd0, 8'd200, 8'd100, 8'd44,  8'd0,    1'b1, 1'b0, 1'b0, 1};
    tbl[1] = '{2'd1, 8'd5,   8'd7,   8'd254, 8'd0,    1'b1, 1'b0, 1'b0, 1};
    tbl[2] = '{2'd2, 8'd255, 8'd255, 8'h01,  8'hFE,   1'b0, 1'b1, 1'b0, 9};
    tbl[3] = '{2'd2, 8'd12,  8'd10,  8'd120, 8'd0,    1'b0, 1'b0, 1'b0, 9};
    tbl[4] = '{2'd3, 8'd200, 8'd7,   8'd28,  8'd4,    1'b0, 1'b0, 1'b0, 9};
    tbl[5] = '{2'd3, 8'd9,   8'd0,   8'd0,   8'd0,    1'b0, 1'b0, 1'b1, 1};

    // Reset and idle
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst outs", int'({res, res_hi, carry, ovf, dz}), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle busy", int'(busy), 0);
    chk("idle outs", int'({done, res, res_hi, carry, ovf, dz}), 0);

    // Directed table
    for (int i = 0; i < 6; i++) run_op(tbl[i], $sformatf("tbl%0d", i));

    // Randomized ops vs model
    for (int i = 0; i < 40; i++) begin
      logic [1:0] ro;
      logic [7:0] ra, rb;
      ro = 2'($urandom);
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_op(model(ro, ra, rb), $sformatf("rnd%0d", i));
    end

    // Busy rejection: add request at T+3 during a multiply is ignored
    @(negedge clk);
    op = 2'd2; a = 8'd3; b = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    ndone = 0; dk = 0; dres = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start = (k == 3);
      if (k == 3) begin op = 2'd0; a = 8'd1; b = 8'd1; end
      @(posedge clk); #1;
      if (busy && done) chk("busy&done", 1, 0);
      if (done) begin ndone++; dk = k; dres = res; end
    end
    chk("rej done count", ndone, 1);
    chk("rej done cycle", dk, 9);
    chk("rej result", int'(dres), 12);
    prev_res = 8'd12;

    // Reset mid-divide: no done, outputs cleared, then a fresh add works
    @(negedge clk);
    op = 2'd3; a = 8'd100; b = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      rst_n = (k != 4);
      @(posedge clk); #1;
      if (done) ndone++;
      if (k == 4) begin
        chk("midrst busy", int'(busy), 0);
        chk("midrst outs", int'({res, res_hi, carry, ovf, dz}), 0);
      end
    end
    chk("midrst no done", ndone, 0);
    prev_res = '0;
    run_op(model(2'd0, 8'd2, 8'd3), "post-rst add");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
